// File: rtl/param_counter.sv
// -----------------------------------------------------------------------------
// param_counter
//
// Parametrised up/down modulo counter with wrap or saturate behaviour at the
// range boundaries. Counts over 0..MODULUS-1 in WIDTH-bit arithmetic.
//
// Parameters
//   WIDTH     counter width in bits (1..32)
//   MODULUS   count range 0..MODULUS-1, legal range 2..2**WIDTH
//   SATURATE  0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous reset, active-low
//   i_clr       synchronous clear to 0 (highest priority)
//   i_load      synchronous parallel load of i_d, clamped to MODULUS-1
//   i_d         load value
//   i_en        count enable
//   i_up_dn     1 = count up, 0 = count down
//   i_flag_clr  clears the sticky o_ovf / o_unf flags
//   o_q         current count (registered)
//   o_tc        terminal count for the current direction (combinational)
//   o_wrap      one-cycle pulse following each boundary event (registered)
//   o_ovf       sticky up-direction boundary event flag
//   o_unf       sticky down-direction boundary event flag
// -----------------------------------------------------------------------------
module param_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_flag_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_ovf,
  output logic             o_unf
);

  // MODULUS is 64-bit so that MODULUS = 2**32 is representable; the top
  // count always fits in WIDTH bits for any legal MODULUS.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] Zero   = '0;
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_ovf_next;
  logic             w_unf_next;

  logic             w_at_top;
  logic             w_at_bot;
  logic             w_count;
  logic             w_bnd_evt;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_top = (r_q == MaxVal);
  assign w_at_bot = (r_q == Zero);

  // A count only happens when neither clear nor load claims the edge.
  assign w_count   = i_en & ~i_clr & ~i_load;

  // Boundary event: an enabled count attempted while sitting at the boundary
  // of the current direction. Covers both a wrap and a blocked saturation.
  assign w_bnd_evt = w_count & (i_up_dn ? w_at_top : w_at_bot);

  // Out-of-range load values clamp to the top of the count range.
  assign w_load_val = (i_d > MaxVal) ? MaxVal : i_d;

  // Next-state count. Every candidate stays within 0..MaxVal, so no
  // intermediate value escapes the modulus.
  always_comb begin
    w_q_next = r_q;
    if (i_clr) begin
      w_q_next = Zero;
    end else if (i_load) begin
      w_q_next = w_load_val;
    end else if (i_en) begin
      if (i_up_dn) begin
        if (!w_at_top) begin
          w_q_next = r_q + One;
        end else if (!SATURATE) begin
          w_q_next = Zero;
        end
      end else begin
        if (!w_at_bot) begin
          w_q_next = r_q - One;
        end else if (!SATURATE) begin
          w_q_next = MaxVal;
        end
      end
    end
  end

  // Sticky flags: a new event on this edge wins over a simultaneous clear.
  always_comb begin
    w_wrap_next = w_bnd_evt;
    w_ovf_next  = r_ovf;
    w_unf_next  = r_unf;
    if (i_flag_clr) begin
      w_ovf_next = 1'b0;
      w_unf_next = 1'b0;
    end
    if (w_bnd_evt && i_up_dn) begin
      w_ovf_next = 1'b1;
    end
    if (w_bnd_evt && !i_up_dn) begin
      w_unf_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= Zero;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
      r_ovf  <= w_ovf_next;
      r_unf  <= w_unf_next;
    end
  end

  assign o_q    = r_q;
  assign o_wrap = r_wrap;
  assign o_ovf  = r_ovf;
  assign o_unf  = r_unf;

  // Terminal count follows the direction input directly, regardless of i_en.
  assign o_tc   = i_up_dn ? w_at_top : w_at_bot;

endmodule

// File: tb/tb_param_counter.sv
// Directed and randomised bench for param_counter. Three instances share the
// stimulus: modulus 10 wrapping, modulus 10 saturating, modulus 16 wrapping.
module tb_param_counter;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] d;
  logic       en;
  logic       up_dn;
  logic       flag_clr;

  logic [3:0] q_a, q_s, q_f;
  logic       tc_a, tc_s, tc_f;
  logic       wrap_a, wrap_s, wrap_f;
  logic       ovf_a, ovf_s, ovf_f;
  logic       unf_a, unf_s, unf_f;

  int n_checks;
  int n_errors;

  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_d(d), .i_en(en),
    .i_up_dn(up_dn), .i_flag_clr(flag_clr),
    .o_q(q_a), .o_tc(tc_a), .o_wrap(wrap_a), .o_ovf(ovf_a), .o_unf(unf_a)
  );

  param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_d(d), .i_en(en),
    .i_up_dn(up_dn), .i_flag_clr(flag_clr),
    .o_q(q_s), .o_tc(tc_s), .o_wrap(wrap_s), .o_ovf(ovf_s), .o_unf(unf_s)
  );

  param_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_d(d), .i_en(en),
    .i_up_dn(up_dn), .i_flag_clr(flag_clr),
    .o_q(q_f), .o_tc(tc_f), .o_wrap(wrap_f), .o_ovf(ovf_f), .o_unf(unf_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; load = 1'b0; d = 4'd0; en = 1'b0; up_dn = 1'b1; flag_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_checks++;
    if (q_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got q=%0d wrap=%b ovf=%b unf=%b, expected 0 0 0 0",
               q_a, wrap_a, ovf_a, unf_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (tc_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_tc: got %b expected 0 (q=0, counting up)", tc_a);
    end
  endtask

  task automatic test_count_up();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++;
      if (q_a !== 4'(i % 10) || tc_a !== (i == 9) || wrap_a !== (i == 10) ||
          ovf_a !== (i == 10)) begin
        n_errors++;
        $display("FAIL count_up[%0d]: got q=%0d tc=%b wrap=%b ovf=%b, expected %0d %b %b %b",
                 i, q_a, tc_a, wrap_a, ovf_a, i % 10, i == 9, i == 10, i == 10);
      end
    end
    en = 1'b0;
    step();
    n_checks++;
    if (q_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b1) begin
      n_errors++;
      $display("FAIL count_up_hold: got q=%0d wrap=%b ovf=%b, expected 0 0 1",
               q_a, wrap_a, ovf_a);
    end
  endtask

  task automatic test_count_down();
    en = 1'b1; up_dn = 1'b0;
    step();
    n_checks++;
    if (q_a !== 4'd9 || wrap_a !== 1'b1 || unf_a !== 1'b1 || ovf_a !== 1'b1 ||
        tc_a !== 1'b0) begin
      n_errors++;
      $display("FAIL down_wrap: got q=%0d wrap=%b unf=%b ovf=%b tc=%b, expected 9 1 1 1 0",
               q_a, wrap_a, unf_a, ovf_a, tc_a);
    end
    en = 1'b0; flag_clr = 1'b1;
    step();
    n_checks++;
    if (q_a !== 4'd9 || wrap_a !== 1'b0 || unf_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_errors++;
      $display("FAIL flag_clr: got q=%0d wrap=%b unf=%b ovf=%b, expected 9 0 0 0",
               q_a, wrap_a, unf_a, ovf_a);
    end
    // New event on the same edge as flag_clr keeps the flag set.
    en = 1'b1; up_dn = 1'b1;
    step();
    n_checks++;
    if (q_a !== 4'd0 || wrap_a !== 1'b1 || ovf_a !== 1'b1 || unf_a !== 1'b0) begin
      n_errors++;
      $display("FAIL set_wins: got q=%0d wrap=%b ovf=%b unf=%b, expected 0 1 1 0",
               q_a, wrap_a, ovf_a, unf_a);
    end
    en = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] exp_q [5];
    exp_q = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    load = 1'b1; d = 4'd7; flag_clr = 1'b1;
    step();
    n_checks++;
    if (q_s !== 4'd7 || wrap_s !== 1'b0 || ovf_s !== 1'b0 || unf_s !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_load: got q=%0d wrap=%b ovf=%b unf=%b, expected 7 0 0 0",
               q_s, wrap_s, ovf_s, unf_s);
    end
    load = 1'b0; flag_clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (q_s !== exp_q[i] || wrap_s !== (i >= 2) || ovf_s !== (i >= 2) ||
          tc_s !== (i >= 1)) begin
        n_errors++;
        $display("FAIL sat_up[%0d]: got q=%0d wrap=%b ovf=%b tc=%b, expected %0d %b %b %b",
                 i, q_s, wrap_s, ovf_s, tc_s, exp_q[i], i >= 2, i >= 2, i >= 1);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clear();
    load = 1'b1; d = 4'd12;
    step();
    n_checks++;
    if (q_a !== 4'd9 || wrap_a !== 1'b0 || wrap_s !== 1'b0 || q_f !== 4'd12) begin
      n_errors++;
      $display("FAIL load_clamp: got q=%0d wrap=%b sat_wrap=%b full_q=%0d, expected 9 0 0 12",
               q_a, wrap_a, wrap_s, q_f);
    end
    clr = 1'b1; d = 4'd5; en = 1'b1;
    step();
    n_checks++;
    if (q_a !== 4'd0 || q_f !== 4'd0 || wrap_a !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_over_load: got q=%0d full_q=%0d wrap=%b, expected 0 0 0",
               q_a, q_f, wrap_a);
    end
    clr = 1'b0;
    step();
    n_checks++;
    if (q_a !== 4'd5 || wrap_a !== 1'b0) begin
      n_errors++;
      $display("FAIL load_over_en: got q=%0d wrap=%b, expected 5 0", q_a, wrap_a);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (q_a !== 4'd6 || ovf_a !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset: got q=%0d ovf=%b, expected 6 1", q_a, ovf_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (q_a !== 4'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0 || wrap_a !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got q=%0d ovf=%b unf=%b wrap=%b, expected 0 0 0 0",
               q_a, ovf_a, unf_a, wrap_a);
    end
    step();
    n_checks++;
    if (q_a !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_hold: got q=%0d expected 0", q_a);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q_a !== 4'd0 || wrap_a !== 1'b0) begin
        n_errors++;
        $display("FAIL en_low_hold[%0d]: got q=%0d wrap=%b, expected 0 0", i, q_a, wrap_a);
      end
    end
  endtask

  task automatic test_full_range();
    load = 1'b1; d = 4'd15; up_dn = 1'b1;
    step();
    n_checks++;
    if (q_f !== 4'd15 || tc_f !== 1'b1 || q_a !== 4'd9) begin
      n_errors++;
      $display("FAIL full_load: got q=%0d tc=%b m10_q=%0d, expected 15 1 9", q_f, tc_f, q_a);
    end
    load = 1'b0; en = 1'b1;
    step();
    n_checks++;
    if (q_f !== 4'd0 || wrap_f !== 1'b1 || ovf_f !== 1'b1 || unf_f !== 1'b0) begin
      n_errors++;
      $display("FAIL full_up_wrap: got q=%0d wrap=%b ovf=%b unf=%b, expected 0 1 1 0",
               q_f, wrap_f, ovf_f, unf_f);
    end
    up_dn = 1'b0;
    step();
    n_checks++;
    if (q_f !== 4'd15 || wrap_f !== 1'b1 || unf_f !== 1'b1) begin
      n_errors++;
      $display("FAIL full_down_wrap: got q=%0d wrap=%b unf=%b, expected 15 1 1",
               q_f, wrap_f, unf_f);
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    int mod [3];
    bit sat [3];
    int mq [3];
    bit mw [3];
    bit mo [3];
    bit mu [3];
    logic [3:0] oq [3];
    logic ow [3];
    logic oo [3];
    logic ou [3];
    logic ot [3];
    bit bnd;
    bit etc;
    mod = '{10, 10, 16};
    sat = '{1'b0, 1'b1, 1'b0};
    idle_inputs();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; mw[k] = 1'b0; mo[k] = 1'b0; mu[k] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      en       = ($urandom_range(0, 9) < 7);
      up_dn    = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 9) == 0);
      clr      = ($urandom_range(0, 19) == 0);
      flag_clr = ($urandom_range(0, 9) == 0);
      d        = 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) begin
        bnd = en && !clr && !load && (up_dn ? (mq[k] == mod[k] - 1) : (mq[k] == 0));
        if (clr) mq[k] = 0;
        else if (load) mq[k] = (int'(d) > mod[k] - 1) ? mod[k] - 1 : int'(d);
        else if (en && up_dn) mq[k] = (mq[k] == mod[k] - 1) ? (sat[k] ? mq[k] : 0) : mq[k] + 1;
        else if (en) mq[k] = (mq[k] == 0) ? (sat[k] ? 0 : mod[k] - 1) : mq[k] - 1;
        mw[k] = bnd;
        if (flag_clr) begin mo[k] = 1'b0; mu[k] = 1'b0; end
        if (bnd && up_dn) mo[k] = 1'b1;
        if (bnd && !up_dn) mu[k] = 1'b1;
      end
      step();
      oq = '{q_a, q_s, q_f};
      ow = '{wrap_a, wrap_s, wrap_f};
      oo = '{ovf_a, ovf_s, ovf_f};
      ou = '{unf_a, unf_s, unf_f};
      ot = '{tc_a, tc_s, tc_f};
      for (int k = 0; k < 3; k++) begin
        etc = up_dn ? (mq[k] == mod[k] - 1) : (mq[k] == 0);
        n_checks++;
        if (int'(oq[k]) != mq[k] || ow[k] !== mw[k] || oo[k] !== mo[k] || ou[k] !== mu[k] ||
            ot[k] !== etc) begin
          n_errors++;
          $display("FAIL random[%0d] inst%0d: got q=%0d wrap=%b ovf=%b unf=%b tc=%b, expected %0d %b %b %b %b",
                   c, k, oq[k], ow[k], oo[k], ou[k], ot[k], mq[k], mw[k], mo[k], mu[k], etc);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_clear();
    test_async_reset();
    test_full_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
